if_fetch_unit: RTL and testbench

- Instruction-fetch front end of the 5-stage ARM pipeline, directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake with variable latency.
- Buffers returned words in a small prefetch queue and presents one {PC, instruction} pair per cycle to the IF/ID register.
- Handles hazard-unit Freeze and EX-stage branch redirects, including discarding stale in-flight responses.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_fetch_unit_queue.sv | 70 +++++++
 rtl/if_fetch_unit.sv | 114 +++++++++++
 tb/tb_if_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The entry layout matches what the IF/ID register consumes.
package if_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/if_fetch_unit_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush beats push and pop.
// Storage is not reset, only pointers and occupancy are.
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               entry,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            empty;
    logic            full;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= entry;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited memory requests,
// drops responses made stale by a redirect and presents queued words to IF/ID.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                QUEUE_DEPTH     = 2,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Freeze,
    input  logic               Branch_taken,
    input  logic [ADDR_W-1:0]  Branch_Address,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               valid_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [ADDR_W-1:0]  PC_out
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int SW = ((OW > CW) ? OW : CW) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] branch_target;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     discard_cnt;
    logic [OW-1:0]     live_outstanding;
    logic [CW-1:0]     queue_count;
    logic [SW-1:0]     in_flight;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              credit_ok;
    logic              fire;
    logic              rsp_accept;
    logic              rsp_keep;
    logic              push;
    logic              pop;
    logic              have_head;

    assign branch_target = word_align(Branch_Address);

    // Credit: queued words plus non-stale fetches in flight never exceed the queue size.
    assign live_outstanding = outstanding - discard_cnt;
    assign in_flight        = SW'(queue_count) + SW'(live_outstanding);
    assign credit_ok        = (in_flight < SW'(QUEUE_DEPTH)) &&
                              (outstanding < OW'(MAX_OUTSTANDING));

    assign imem_req  = credit_ok && !Branch_taken && !rst;
    assign imem_addr = fetch_pc;
    assign fire      = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_accept = imem_rvalid && (outstanding != '0);
    assign rsp_keep   = rsp_accept && (discard_cnt == '0);
    assign push       = rsp_keep && !Branch_taken;

    assign push_entry.pc    = resp_pc;
    assign push_entry.instr = imem_rdata;

    assign have_head = (queue_count != '0);
    assign pop       = valid_out && !Freeze && !Branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            outstanding <= outstanding + OW'(fire) - OW'(rsp_accept);
            if (Branch_taken) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc    <= branch_target;
                resp_pc     <= branch_target;
                discard_cnt <= outstanding - OW'(rsp_accept);
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp_accept && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - OW'(1);
                end else if (rsp_accept) begin
                    resp_pc <= resp_pc + PC_STEP;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (Branch_taken),
        .entry (push_entry),
        .count (queue_count),
        .head  (head)
    );

    // Outputs read as a bubble whenever no head is presented.
    assign valid_out       = have_head && !rst;
    assign instruction_out = valid_out ? head.instr : NOP_INSTR;
    assign PC_out          = valid_out ? (head.pc + PC_STEP) : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-level reference model
// of the fetch stream, with a variable-latency in-order memory model.
module tb_if_fetch_unit;

    localparam int          QD       = 2;
    localparam int          MO       = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        Freeze;
    logic        Branch_taken;
    logic [31:0] Branch_Address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic [31:0] instruction_out;
    logic [31:0] PC_out;

    if_fetch_unit #(
        .QUEUE_DEPTH     (QD),
        .MAX_OUTSTANDING (MO),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Freeze          (Freeze),
        .Branch_taken    (Branch_taken),
        .Branch_Address  (Branch_Address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .valid_out       (valid_out),
        .instruction_out (instruction_out),
        .PC_out          (PC_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } pend_t;

    pend_t       pending[$];
    logic [31:0] q[$];
    logic [31:0] exp_fetch;
    int          epoch;
    int          cyc;
    int          vec_cnt;
    int          miscompares;

    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_gnt;
    logic        s_br;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic run_cycle(input logic r, input logic fz, input logic bt, input logic bt_on_rv,
                             input logic [31:0] ba, input int gnt_pct,
                             input int lat_lo, input int lat_hi);
        logic  do_rv;
        logic  bt_eff;
        logic  exp_v;
        logic  exp_req;
        int    live;
        pend_t pe;
        @(negedge clk);
        cyc++;
        do_rv  = !r && (pending.size() > 0) && (pending[0].ready <= cyc);
        if (do_rv) assert (pending.size() > 0);
        bt_eff = !r && (bt || (bt_on_rv && do_rv));
        rst            = r;
        Freeze         = fz;
        Branch_taken   = bt_eff;
        Branch_Address = ba;
        imem_gnt       = ($urandom_range(0, 99) < gnt_pct);
        imem_rvalid    = do_rv;
        imem_rdata     = do_rv ? mem_word(pending[0].addr) : $urandom;
        #1;
        s_valid = valid_out; s_pc = PC_out; s_instr = instruction_out;
        s_req = imem_req; s_addr = imem_addr; s_gnt = imem_gnt; s_br = bt_eff;

        exp_v = !r && (q.size() > 0);
        chk("valid", valid_out, exp_v);
        if (exp_v) begin
            chk("pc", PC_out, q[0] + 32'd4);
            chk("instr", instruction_out, mem_word(q[0]));
        end else begin
            chk("pc_bubble", PC_out, 32'h0);
            chk("instr_bubble", instruction_out, 32'h0);
        end
        live = 0;
        foreach (pending[i]) if (pending[i].epoch == epoch) live++;
        exp_req = !r && !bt_eff && ((q.size() + live) < QD) && (pending.size() < MO);
        chk("req", imem_req, exp_req);
        if (imem_req) chk("addr", imem_addr, exp_fetch);

        if (r) begin
            q.delete();
            pending.delete();
            epoch++;
            exp_fetch = RESET_PC;
        end else begin
            pe = '{addr: 32'h0, epoch: -1, ready: 0};
            if (do_rv) pe = pending.pop_front();
            if (imem_req && imem_gnt) begin
                pending.push_back('{addr: imem_addr, epoch: epoch,
                                    ready: cyc + 1 + $urandom_range(lat_lo, lat_hi)});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (bt_eff) begin
                q.delete();
                epoch++;
                exp_fetch = {ba[31:2], 2'b00};
            end else begin
                if (exp_v && !fz) void'(q.pop_front());
                if (do_rv && pe.epoch == epoch) q.push_back(pe.addr);
            end
        end
        chk("q_overflow", 32'(q.size() <= QD), 32'd1);
        chk("outstanding_cap", 32'(pending.size() <= MO), 32'd1);
    endtask

    task automatic do_reset();
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0, 0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0, 0);
    endtask

    initial begin
        logic found;
        rst = 1'b1; Freeze = 1'b0; Branch_taken = 1'b0; Branch_Address = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        cyc = 0; epoch = 0; vec_cnt = 0; miscompares = 0; exp_fetch = RESET_PC;

        // 0-wait memory from reset, explicit start address check
        do_reset();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0, 0);
        chk("t1_first_addr", s_addr, RESET_PC);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0, 0);

        // Freeze with a full queue: credit runs out, head holds
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 100, 0, 0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 100, 0, 0);
        chk("t2_req_frozen", s_req, 1'b0);
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0, 0);

        // Redirect to 0x100 with two fetches in flight
        do_reset();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 100, 3, 3);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 100, 3, 3);
        chk("t3_two_outstanding", pending.size(), 32'd2);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 100, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0, 0);
            if (s_valid) begin
                found = 1'b1;
                chk("t3_pc", s_pc, 32'h0000_0104);
                chk("t3_instr", s_instr, mem_word(32'h0000_0100));
            end
        end
        if (!found) chk("t3_timeout", 32'd0, 32'd1);

        // Redirect to 0x203 coinciding with rvalid and Freeze
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0203, 100, 1, 2);
            found = s_br;
        end
        if (!found) chk("t4_no_branch", 32'd0, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0, 0);
            if (s_req) begin
                found = 1'b1;
                chk("t4_addr", s_addr, 32'h0000_0200);
            end
        end
        if (!found) chk("t4_timeout", 32'd0, 32'd1);

        // Random latency, grants, freezes, branches and occasional resets
        for (int i = 0; i < 10000; i++) begin
            run_cycle(($urandom_range(0, 999) < 2), ($urandom_range(0, 99) < 30),
                      ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 2),
                      $urandom, 60, 0, 5);
        end

        // Reset mid-stream with one fetch outstanding
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 50, 2, 5);
            found = (pending.size() == 1);
        end
        if (!found) chk("t6_no_outstanding", 32'd0, 32'd1);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0, 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0);
        chk("t6_valid", s_valid, 1'b0);
        chk("t6_pc", s_pc, 32'h0);
        chk("t6_instr", s_instr, 32'h0);
        chk("t6_addr", s_addr, RESET_PC);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
